// File: rtl/dct32_pkg.sv
// Shared definitions for the DCT32 host transfer engine and accelerator side.
//   DCT32_WORDS  : words per transform (both directions)
//   dma_state_e  : transfer engine state encoding
//   dma_is_busy  : states in which the engine reports busy
package dct32_pkg;

  localparam int unsigned DCT32_WORDS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_PUSH,
    ST_DRAIN,
    ST_FINISH
  } dma_state_e;

  // FINISH is excluded: busy drops in the same cycle done pulses.
  function automatic logic dma_is_busy(input dma_state_e s);
    return (s == ST_FETCH) || (s == ST_CAPTURE) || (s == ST_PUSH) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/dct32_dma_watchdog.sv
// Stall watchdog for dct32_dma (only instantiated with DCT32_DMA_TIMEOUT_EN).
// Counts consecutive stalled cycles and flags expiry on the TIMEOUT-th one.
//   clk     : clock
//   rst     : synchronous active-high reset
//   stall   : engine is waiting on a FIFO this cycle
//   expired : this cycle is the TIMEOUT-th consecutive stall
module dct32_dma_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any non-stalled cycle (a transfer or any other state) restarts the count.
  always_comb begin
    cnt_d   = '0;
    expired = 1'b0;
    if (stall) begin
      cnt_d   = cnt_q + 1'b1;
      expired = (cnt_q == LAST_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dct32_dma.sv
// Host-side transfer engine for the DCT32 accelerator.
// On start it reads WORDS consecutive RAM words and pushes them into the
// argument FIFO, then pops WORDS results and writes them back to RAM.
// Optional macro DCT32_DMA_TIMEOUT_EN adds a stall watchdog that aborts the
// job with err=1 after TIMEOUT consecutive stalled cycles.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start, src_base, dst_base   : job request and RAM base addresses
//   busy, done, err             : job status (err valid with done)
//   mem_addr, mem_rd_en, mem_rd_data, mem_wr_en, mem_wr_data : RAM port
//   iarg_full, iarg_d, iarg_write : argument FIFO push side
//   oarg_empty, oarg_d, oarg_read : result FIFO pop side (FWFT)
module dct32_dma
  import dct32_pkg::*;
#(
  parameter int unsigned WORDS   = DCT32_WORDS,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  input  logic              iarg_full,
  output logic [31:0]       iarg_d,
  output logic              iarg_write,
  input  logic              oarg_empty,
  input  logic [31:0]       oarg_d,
  output logic              oarg_read
);

  localparam int unsigned IDX_W = $clog2(WORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  dma_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [31:0]       hold_q, hold_d;

`ifdef DCT32_DMA_TIMEOUT_EN
  logic err_q, err_d;
  logic stall, expired;

  assign stall = ((state_q == ST_PUSH) && iarg_full) ||
                 ((state_q == ST_DRAIN) && oarg_empty);

  dct32_dma_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .expired (expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    src_d       = src_q;
    dst_d       = dst_q;
    hold_d      = hold_q;
`ifdef DCT32_DMA_TIMEOUT_EN
    err_d       = err_q;
`endif
    busy        = dma_is_busy(state_q);
    done        = 1'b0;
    err         = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    iarg_d      = '0;
    iarg_write  = 1'b0;
    oarg_read   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          idx_d   = '0;
`ifdef DCT32_DMA_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Address arithmetic wraps modulo 2^ADDR_W by truncation.
        mem_rd_en = 1'b1;
        mem_addr  = src_q + ADDR_W'(idx_q);
        state_d   = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        hold_d  = mem_rd_data;
        state_d = ST_PUSH;
      end

      ST_PUSH: begin
        iarg_d     = hold_q;
        iarg_write = !iarg_full;
        if (!iarg_full) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
`ifdef DCT32_DMA_TIMEOUT_EN
        else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
`endif
      end

      ST_DRAIN: begin
        // Pop and write-back happen together: the FWFT head goes straight to RAM.
        oarg_read   = !oarg_empty;
        mem_wr_en   = !oarg_empty;
        mem_addr    = dst_q + ADDR_W'(idx_q);
        mem_wr_data = oarg_d;
        if (!oarg_empty) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
          end
        end
`ifdef DCT32_DMA_TIMEOUT_EN
        else if (expired) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end
`endif
      end

      ST_FINISH: begin
        done    = 1'b1;
`ifdef DCT32_DMA_TIMEOUT_EN
        err     = err_q;
`endif
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      hold_q  <= hold_d;
    end
  end

`ifdef DCT32_DMA_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule
